// File: rtl/sdram_arbiter_pkg.sv
// ============================================================================
// Package : sdram_arbiter_pkg
// Purpose : Shared types and constants for the SDRAM port arbiter: the
//           arbiter FSM state encoding, the grant-kind codes that keep a
//           download write distinct from any read tag, and the tag width
//           helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // A grant is {kind, index}. WRITE is its own kind so it can never alias a
  // read tag, and it is never pushed into the return-order FIFO.
  localparam logic GNT_KIND_READ  = 1'b0;
  localparam logic GNT_KIND_WRITE = 1'b1;

  // Width of a read tag; at least one bit even for a single requester.
  function automatic int tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
// ============================================================================
// Interface : sdram_arbiter_if
// Purpose   : Request/acknowledge bus between the arbiter and the SDRAM
//             controller.
// Signals   : req/we/addr/data  - request from the arbiter
//             ack               - controller accepted the current request
//             valid             - read data from the controller is valid
// Modports  : master (arbiter side), slave (controller side)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  ack;
  logic                  valid;

  modport master (output req, we, addr, data, input ack, valid);
  modport slave  (input req, we, addr, data, output ack, valid);

endinterface

`default_nettype wire

// File: rtl/sdram_arbiter_tag_fifo.sv
// ============================================================================
// Module  : tag_fifo
// Purpose : Synchronous DEPTH-entry FIFO holding the requester index of each
//           accepted read, in issue order. Push and pop may happen together,
//           including push while full (when a pop frees the slot).
// Ports   : clk, reset     - clock, asynchronous active-high reset
//           i_push, i_data - write a tag
//           i_pop          - drop the head tag (ignored when empty)
//           o_head         - tag at the head
//           o_full/o_empty - occupancy flags
// Notes   : DEPTH must be a power of two, 2 or more.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module  : sdram_arbiter
// Purpose : Shares one SDRAM port between a download write channel and
//           NUM_REQ read requesters (index 0 highest priority). Writes win
//           outright; a read requester that has lost STARVE_LIMIT decisions
//           is forced to win. Accepted reads are tagged in order so each
//           returned word is steered to its requester.
// Ports   : clk, reset                 - clock, asynchronous active-high reset
//           i_rd_req/i_rd_addr         - per-requester read request/address
//           o_rd_ack/o_rd_valid        - acceptance / data-return pulses
//           i_wr_req/i_wr_addr/i_wr_data, o_wr_ack - download write channel
//           sdram                      - controller bus (master modport)
//           o_err                      - sticky: data returned with no
//                                        outstanding read
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 23,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic [NUM_REQ-1:0]            i_rd_req,
  input  wire logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr,
  output logic      [NUM_REQ-1:0]            o_rd_ack,
  output logic      [NUM_REQ-1:0]            o_rd_valid,
  input  wire logic                          i_wr_req,
  input  wire logic [ADDR_WIDTH-1:0]         i_wr_addr,
  input  wire logic [DATA_WIDTH-1:0]         i_wr_data,
  output logic                               o_wr_ack,
  sdram_arbiter_if.master                    sdram,
  output logic                               o_err
);

  localparam int TAG_W = tag_w(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e            r_state;
  logic                  r_gnt_kind;
  logic [TAG_W-1:0]      r_gnt_idx;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [CNT_W-1:0]      r_starve [NUM_REQ];

  logic [ADDR_WIDTH-1:0] w_rd_addr [NUM_REQ];
  logic                  w_have_cand;
  logic                  w_sel_wr;
  logic [TAG_W-1:0]      w_sel_idx;
  logic                  w_decide;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [TAG_W-1:0]      w_head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_rd_addr[g] = i_rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Candidate: write first; else a starved reader; else the lowest-index
  // reader. Reads are held back while the tag FIFO cannot take another tag.
  // Both loops run high-to-low so the last hit is the lowest index.
  always_comb begin
    w_have_cand = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_idx   = '0;
    if (i_wr_req) begin
      w_have_cand = 1'b1;
      w_sel_wr    = 1'b1;
    end else if (!w_fifo_full) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_rd_req[i]) begin
          w_have_cand = 1'b1;
          w_sel_idx   = TAG_W'(i);
        end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_rd_req[i] && (r_starve[i] >= STARVE_MAX)) w_sel_idx = TAG_W'(i);
      end
    end
  end

  assign w_decide = (r_state == IDLE) && w_have_cand;
  assign w_accept = (r_state == ISSUE) && sdram.ack;
  assign w_push   = w_accept && (r_gnt_kind == GNT_KIND_READ);
  assign w_pop    = sdram.valid && !w_fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt_kind <= GNT_KIND_READ;
      r_gnt_idx  <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (sdram.valid && w_fifo_empty) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_have_cand) begin
            r_gnt_kind <= w_sel_wr ? GNT_KIND_WRITE : GNT_KIND_READ;
            r_gnt_idx  <= w_sel_idx;
            r_we       <= w_sel_wr;
            r_addr     <= w_sel_wr ? i_wr_addr : w_rd_addr[w_sel_idx];
            r_data     <= w_sel_wr ? i_wr_data : '0;
            r_req      <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdram.ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counters only move on a real grant decision; a dropped request clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_starve[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!i_rd_req[i]) begin
          r_starve[i] <= '0;
        end else if (w_decide) begin
          if (!w_sel_wr && (w_sel_idx == TAG_W'(i))) r_starve[i] <= '0;
          else if (r_starve[i] != STARVE_MAX)        r_starve[i] <= r_starve[i] + 1'b1;
        end
      end
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_gnt_idx),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    o_rd_ack   = '0;
    o_rd_valid = '0;
    if (w_push) o_rd_ack[r_gnt_idx] = 1'b1;
    if (w_pop)  o_rd_valid[w_head]  = 1'b1;
  end

  assign o_wr_ack   = w_accept && (r_gnt_kind == GNT_KIND_WRITE);
  assign o_err      = r_err;
  assign sdram.req  = r_req;
  assign sdram.we   = r_we;
  assign sdram.addr = r_addr;
  assign sdram.data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module  : tb_sdram_arbiter
// Purpose : Directed self-checking bench for sdram_arbiter with a simple
//           scripted SDRAM controller and requester behaviour.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    rd_req;
  logic [4*AW-1:0] rd_addr;
  logic [3:0]    rd_ack;
  logic [3:0]    rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          err;

  sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sdram ();

  sdram_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(2), .STARVE_LIMIT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_ack   (rd_ack),
    .o_rd_valid (rd_valid),
    .i_wr_req   (wr_req),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_ack   (wr_ack),
    .sdram      (sdram),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Handshake log, sampled mid-cycle. Grant code 4 means the write channel.
  logic [3:0]    s_rd_ack = '0;
  logic          s_wr_ack = 1'b0;
  logic          s_req    = 1'b0;
  int            gnt_q[$];
  logic          we_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int            val_q[$];

  always @(negedge clk) begin
    s_rd_ack = rd_ack;
    s_wr_ack = wr_ack;
    s_req    = sdram.req;
    if (reset) begin
      gnt_q.delete(); we_q.delete(); addr_q.delete(); data_q.delete(); val_q.delete();
    end else begin
      if (wr_ack) begin
        gnt_q.push_back(4); we_q.push_back(sdram.we);
        addr_q.push_back(sdram.addr); data_q.push_back(sdram.data);
      end
      for (int i = 0; i < 4; i++) begin
        if (rd_ack[i]) begin
          gnt_q.push_back(i); we_q.push_back(sdram.we);
          addr_q.push_back(sdram.addr); data_q.push_back(sdram.data);
        end
        if (rd_valid[i]) val_q.push_back(i);
      end
    end
  end

  logic       auto_ack;
  logic       auto_valid;
  logic [3:0] drop_mask;

  // Advance one cycle; requesters drop on ack, optional scripted controller.
  task automatic cyc();
    @(posedge clk); #1;
    rd_req = rd_req & ~(s_rd_ack & drop_mask);
    if (s_wr_ack) wr_req = 1'b0;
    if (auto_ack)   sdram.ack   = s_req & ~sdram.ack;
    if (auto_valid) sdram.valid = |s_rd_ack;
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (gnt_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    if (gnt_q.size() < n) check_eq(tag, 64'(gnt_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1; rd_req = '0; wr_req = 1'b0;
    sdram.ack = 1'b0; sdram.valid = 1'b0;
    auto_ack = 1'b0; auto_valid = 1'b0; drop_mask = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pos;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // ---------------- reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_req",   64'(sdram.req),  64'(0));
    check_eq("rst_we",    64'(sdram.we),   64'(0));
    check_eq("rst_addr",  64'(sdram.addr), 64'(0));
    check_eq("rst_data",  64'(sdram.data), 64'(0));
    check_eq("rst_acks",  64'({rd_ack, wr_ack}), 64'(0));
    check_eq("rst_valid", 64'(rd_valid),   64'(0));
    check_eq("rst_err",   64'(err),        64'(0));

    // ---------------- single read on requester 2
    rd_addr[2*AW +: AW] = 23'h040010;
    cyc();
    rd_req = 4'b0100;
    cyc();
    @(negedge clk);
    check_eq("rd1_req",  64'(sdram.req),  64'(1));
    check_eq("rd1_addr", 64'(sdram.addr), 64'(23'h040010));
    check_eq("rd1_we",   64'(sdram.we),   64'(0));
    cyc(); cyc();
    sdram.ack = 1'b1;
    @(negedge clk);
    check_eq("rd1_ack",   64'(rd_ack), 64'(4'b0100));
    check_eq("rd1_wrack", 64'(wr_ack), 64'(0));
    cyc();
    sdram.ack = 1'b0;
    @(negedge clk);
    check_eq("rd1_req_drop", 64'(sdram.req), 64'(0));
    cyc(); cyc();
    sdram.valid = 1'b1;
    @(negedge clk);
    check_eq("rd1_valid", 64'(rd_valid), 64'(4'b0100));
    cyc();
    sdram.valid = 1'b0;
    cyc();
    check_eq("rd1_nacks",   64'(gnt_q.size()), 64'(1));
    check_eq("rd1_nvalids", 64'(val_q.size()), 64'(1));
    check_eq("rd1_err",     64'(err),          64'(0));

    // ---------------- priority: write, then 0, then 3
    do_reset();
    auto_ack = 1'b1; auto_valid = 1'b1;
    rd_addr[0 +: AW]    = 23'h000100;
    rd_addr[3*AW +: AW] = 23'h7ABCDE;
    wr_addr = 23'h123456; wr_data = 32'hDEADBEEF;
    rd_req = 4'b1001; wr_req = 1'b1;
    wait_grants(3, 40, "prio_timeout");
    check_eq("prio_g0",    64'(gnt_q[0]),  64'(4));
    check_eq("prio_g1",    64'(gnt_q[1]),  64'(0));
    check_eq("prio_g2",    64'(gnt_q[2]),  64'(3));
    check_eq("prio_we",    64'({we_q[0], we_q[1], we_q[2]}), 64'(3'b100));
    check_eq("prio_waddr", 64'(addr_q[0]), 64'(23'h123456));
    check_eq("prio_wdata", 64'(data_q[0]), 64'(32'hDEADBEEF));
    check_eq("prio_addr0", 64'(addr_q[1]), 64'(23'h000100));
    check_eq("prio_addr3", 64'(addr_q[2]), 64'(23'h7ABCDE));
    repeat (4) cyc();
    check_eq("prio_nvalid", 64'(val_q.size()), 64'(2));
    check_eq("prio_vorder", 64'({val_q[0][3:0], val_q[1][3:0]}), 64'(8'h03));
    check_eq("prio_err",    64'(err), 64'(0));

    // ---------------- starvation: 3 wins after 16 lost decisions
    do_reset();
    auto_ack = 1'b1; auto_valid = 1'b1; drop_mask = 4'b1000;
    rd_req = 4'b1001;
    wait_grants(17, 300, "starve_timeout");
    pos = -1;
    foreach (gnt_q[i]) if (gnt_q[i] == 3 && pos < 0) pos = i;
    check_eq("starve_pos", 64'(pos),      64'(16));
    check_eq("starve_g15", 64'(gnt_q[15]), 64'(0));
    rd_req = '0;
    repeat (10) cyc();
    check_eq("starve_err", 64'(err), 64'(0));

    // ---------------- outstanding order, DEPTH 2 blocks the third read
    do_reset();
    auto_ack = 1'b1;
    rd_req = 4'b1110;
    repeat (15) cyc();
    check_eq("ord_ngrant", 64'(gnt_q.size()), 64'(2));
    check_eq("ord_g01",    64'({gnt_q[0][3:0], gnt_q[1][3:0]}), 64'(8'h12));
    @(negedge clk);
    check_eq("ord_blocked", 64'(sdram.req), 64'(0));
    cyc();
    sdram.valid = 1'b1;
    @(negedge clk);
    check_eq("ord_v1", 64'(rd_valid), 64'(4'b0010));
    cyc();
    sdram.valid = 1'b0;
    wait_grants(3, 20, "ord_timeout");
    check_eq("ord_g2", 64'(gnt_q[2]), 64'(3));
    cyc(); cyc();
    sdram.valid = 1'b1;
    @(negedge clk);
    check_eq("ord_v2", 64'(rd_valid), 64'(4'b0100));
    cyc();
    @(negedge clk);
    check_eq("ord_v3", 64'(rd_valid), 64'(4'b1000));
    cyc();
    sdram.valid = 1'b0;
    @(negedge clk);
    check_eq("ord_err", 64'(err), 64'(0));

    // ---------------- simultaneous ack and valid, then spurious valid
    do_reset();
    rd_req = 4'b0001;
    cyc();
    sdram.ack = 1'b1;
    @(negedge clk);
    check_eq("sim_ack0", 64'(rd_ack), 64'(4'b0001));
    cyc();
    sdram.ack = 1'b0; rd_req = 4'b0010;
    cyc();
    sdram.ack = 1'b1; sdram.valid = 1'b1;
    @(negedge clk);
    check_eq("sim_ack1",   64'(rd_ack),   64'(4'b0010));
    check_eq("sim_valid0", 64'(rd_valid), 64'(4'b0001));
    cyc();
    sdram.ack = 1'b0;
    @(negedge clk);
    check_eq("sim_valid1", 64'(rd_valid), 64'(4'b0010));
    check_eq("sim_err0",   64'(err),      64'(0));
    cyc();
    @(negedge clk);
    check_eq("sim_empty", 64'(rd_valid), 64'(4'b0000));
    cyc();
    sdram.valid = 1'b0;
    @(negedge clk);
    check_eq("spur_err", 64'(err), 64'(1));
    repeat (5) cyc();
    @(negedge clk);
    check_eq("spur_sticky", 64'(err), 64'(1));

    // ---------------- reset mid-ISSUE with a tag outstanding
    cyc();
    auto_ack = 1'b1;
    base = gnt_q.size();
    rd_req = 4'b0001;
    wait_grants(base + 1, 20, "rst_setup");
    auto_ack = 1'b0;
    rd_req = 4'b0100;
    cyc();
    @(negedge clk);
    check_eq("mid_req",  64'(sdram.req),  64'(1));
    check_eq("mid_addr", 64'(sdram.addr), 64'(23'h040010));
    #1 reset = 1'b1; rd_req = '0;
    #1;
    check_eq("mid_rst_req",  64'(sdram.req),  64'(0));
    check_eq("mid_rst_addr", 64'(sdram.addr), 64'(0));
    check_eq("mid_rst_err",  64'(err),        64'(0));
    check_eq("mid_rst_acks", 64'({rd_ack, wr_ack, rd_valid}), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    sdram.valid = 1'b1;
    @(negedge clk);
    check_eq("post_rst_valid", 64'(rd_valid), 64'(0));
    cyc();
    sdram.valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_err", 64'(err), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
